fu_div_iter: RTL

Parametrised multicycle integer divide functional unit for the pipeline's EX stage. It replaces the vendor-IP divider wrapper with an in-house radix-2 restoring divider. It supports signed and unsigned operation, quotient or remainder select, RISC-V divide-by-zero and overflow semantics, configurable width, and an explicit busy/finish handshake toward the issue/scoreboard logic.

---
 rtl/fu_div_iter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fu_div_iter.sv
// -----------------------------------------------------------------------------
// fu_div_iter - multicycle radix-2 restoring integer divider for the EX stage.
//
// Handles DIV / DIVU / REM / REMU with RISC-V divide-by-zero and signed
// overflow behaviour. A normal operation takes WIDTH iteration edges after
// the accept edge. A zero divisor goes straight to DONE on the accept edge.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset (aborts any operation in flight)
//   EN      issue request, accepted only while busy = 0
//   A, B    dividend / divisor, sampled on the accepting edge
//   op      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   res     result register, valid while finish = 1, then held
//   finish  one-cycle pulse marking res valid
//   busy    unit occupied (RUN or DONE), EN ignored while high
// -----------------------------------------------------------------------------
module fu_div_iter #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             finish,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Two's complement negate when sel is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic sel);
        logic [WIDTH-1:0] n;
        n = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        return sel ? n : v;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       op_r;
    logic [WIDTH-1:0] dvs_r;      // divisor magnitude
    logic [WIDTH-1:0] quo_r;      // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] rem_r;      // partial remainder, always below the divisor magnitude
    logic             q_neg_r;
    logic             r_neg_r;
    logic [WIDTH-1:0] res_r;

    logic             signed_s;
    logic             last_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH-1:0] rem_nx_s;
    logic [WIDTH-1:0] quo_nx_s;
    logic [WIDTH-1:0] result_s;

    // Operand magnitudes for the accept edge; unsigned ops never negate.
    always_comb begin
        signed_s = ~op[0];
        a_mag_s  = cond_neg(A, signed_s & A[WIDTH-1]);
        b_mag_s  = cond_neg(B, signed_s & B[WIDTH-1]);
        last_s   = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // One restoring step plus the sign-corrected result for the final step.
    always_comb begin
        shift_s  = {rem_r, quo_r[WIDTH-1]};
        diff_s   = shift_s - {1'b0, dvs_r};
        rem_nx_s = shift_s[WIDTH-1:0];
        quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
        result_s = {WIDTH{1'b0}};
        // A clear MSB means the trial subtraction did not go negative.
        if (diff_s[WIDTH] == 1'b0) begin
            rem_nx_s = diff_s[WIDTH-1:0];
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx_s = shift_s[WIDTH-1:0];
            quo_nx_s = {quo_r[WIDTH-2:0], 1'b0};
        end
        if (op_r[1]) begin
            result_s = cond_neg(rem_nx_s, r_neg_r);
        end else begin
            result_s = cond_neg(quo_nx_s, q_neg_r);
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (EN) begin
                    if (B == {WIDTH{1'b0}}) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: capture on accept, iterate in RUN, load res on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {CNT_W{1'b0}};
            op_r    <= 2'b00;
            dvs_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            res_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (EN) begin
                        op_r    <= op;
                        dvs_r   <= b_mag_s;
                        quo_r   <= a_mag_s;
                        rem_r   <= {WIDTH{1'b0}};
                        cnt_r   <= {CNT_W{1'b0}};
                        q_neg_r <= signed_s & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r <= signed_s & A[WIDTH-1];
                        // Divide-by-zero: all ones for quotient, raw dividend for remainder.
                        if (B == {WIDTH{1'b0}}) begin
                            res_r <= op[1] ? A : {WIDTH{1'b1}};
                        end
                    end
                end
                ST_RUN: begin
                    rem_r <= rem_nx_s;
                    quo_r <= quo_nx_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        res_r <= result_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign res    = res_r;
    assign finish = (state_r == ST_DONE);
    assign busy   = (state_r != ST_IDLE);

endmodule
